ps2_scan_ctrl: RTL and testbench

- Sequences the PS/2 byte receiver. Consumes its 8-bit byte plus one-cycle done pulse.
- Parses scancode set 2 prefix sequences (E0 extended, F0 break, E1 pause).
- Optionally suppresses typematic repeats and resyncs on stalled sequences.
- Buffers decoded key events in a small FIFO with a valid/ready handshake to the downstream consumer (display/ASCII logic).

---
 rtl/ps2_pkg.sv | 56 +++++
 rtl/ps2_evt_fifo.sv | 68 ++++++
 rtl/ps2_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, parser states and event word layout for the PS/2 scan controller
// Purpose: single source for scancode-set-2 byte values, parser state encoding,
//          the Pause sequence length and the 10-bit event word {ext, brk, code}.
// Ports:   none (package).
package ps2_pkg;

  localparam logic [7:0] PS2_E0     = 8'hE0;
  localparam logic [7:0] PS2_F0     = 8'hF0;
  localparam logic [7:0] PS2_E1     = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Pause is E1 followed by seven more bytes; it is reported as extended 77.
  localparam int         PAUSE_SKIP = 7;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  localparam int EVT_W        = 10;
  localparam int EVT_CODE_LSB = 0;
  localparam int EVT_CODE_MSB = 7;
  localparam int EVT_BRK_BIT  = 8;
  localparam int EVT_EXT_BIT  = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } parse_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_E0) || (b == PS2_F0) || (b == PS2_E1);
  endfunction

  // Keyboard status / protocol bytes that never represent a key.
  function automatic logic is_dropped(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  function automatic logic [EVT_W-1:0] pack_evt(input logic [7:0] code,
                                                input logic       ext,
                                                input logic       brk);
    logic [EVT_W-1:0] w;
    w = '0;
    w[EVT_CODE_MSB:EVT_CODE_LSB] = code;
    w[EVT_BRK_BIT]               = brk;
    w[EVT_EXT_BIT]               = ext;
    return w;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous show-ahead FIFO for decoded key events
// Purpose: DEPTH-entry buffer; head always presents the oldest entry (zero when empty).
// Ports:   clk, reset (sync, active-high); push/push_data write; pop consumes head;
//          head, full, empty status; overflow is sticky when a push is dropped.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot the write lands in, so full does not block it.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_scan_ctrl.sv
// rtl/ps2_scan_ctrl.sv - PS/2 scancode set 2 sequence parser with repeat filter and event FIFO
// Purpose: turns receiver bytes into {code, ext, brk} key events, drops typematic
//          repeats, abandons stalled sequences and buffers events for the consumer.
// Ports:   clk, reset (sync, active-high); rx_data/rx_done byte input;
//          evt_code/evt_ext/evt_break/evt_valid/evt_ready event handshake;
//          fifo_overflow sticky drop flag; seq_error one-cycle error pulse.
module ps2_scan_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       fifo_overflow,
  output logic       seq_error
);

  import ps2_pkg::*;

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  parse_state_t     state;
  parse_state_t     state_next;
  logic [2:0]       skip;
  logic [2:0]       skip_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout;

  logic             emit;
  logic [7:0]       emit_code;
  logic             emit_ext;
  logic             emit_brk;
  logic             emit_pause;
  logic             bad_prefix;

  logic [7:0]       lm_code;
  logic             lm_ext;
  logic             lm_valid;
  logic             lm_match;
  logic             repeat_hit;
  logic             push;

  logic [EVT_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  // A byte arriving on the expiry cycle wins; the counter restarts instead.
  assign timeout = !rx_done && (state != ST_IDLE) && (tmo_cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    skip_next  = skip;
    emit       = 1'b0;
    emit_code  = rx_data;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    emit_pause = 1'b0;
    bad_prefix = 1'b0;
    if (rx_done) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == PS2_E0) begin
            state_next = ST_EXT;
          end else if (rx_data == PS2_F0) begin
            state_next = ST_BRK;
          end else if (rx_data == PS2_E1) begin
            state_next = ST_PAUSE;
            skip_next  = 3'(PAUSE_SKIP);
          end else if (!is_dropped(rx_data)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_F0) begin
            state_next = ST_EXT_BRK;
          end else if (is_prefix(rx_data)) begin
            bad_prefix = 1'b1;
            state_next = ST_IDLE;
          end else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_next = ST_IDLE;
          if (is_prefix(rx_data)) begin
            bad_prefix = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state == ST_EXT_BRK);
          end
        end
        ST_PAUSE: begin
          skip_next = skip - 3'd1;
          if (skip == 3'd1) begin
            emit       = 1'b1;
            emit_pause = 1'b1;
            emit_code  = PAUSE_CODE;
            emit_ext   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else if (timeout) begin
      state_next = ST_IDLE;
    end
  end

  // Pause has no break code and never auto-repeats, so it bypasses the filter;
  // otherwise a second Pause press would be swallowed until another key moved.
  assign lm_match   = lm_valid && (lm_code == emit_code) && (lm_ext == emit_ext);
  assign repeat_hit = (FILTER_REPEAT != 0) && emit && !emit_brk && !emit_pause && lm_match;
  assign push       = emit && !repeat_hit;
  assign pop        = !fifo_empty && evt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      skip      <= '0;
      tmo_cnt   <= '0;
      seq_error <= 1'b0;
    end else begin
      state     <= state_next;
      skip      <= skip_next;
      seq_error <= bad_prefix || timeout;
      if (rx_done || timeout) begin
        tmo_cnt <= '0;
      end else if (state != ST_IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lm_code  <= '0;
      lm_ext   <= 1'b0;
      lm_valid <= 1'b0;
    end else if (emit && !emit_pause) begin
      if (!emit_brk) begin
        if (!repeat_hit) begin
          lm_code  <= emit_code;
          lm_ext   <= emit_ext;
          lm_valid <= 1'b1;
        end
      end else if (lm_match) begin
        lm_valid <= 1'b0;
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pack_evt(emit_code, emit_ext, emit_brk)),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head[EVT_CODE_MSB:EVT_CODE_LSB];
  assign evt_ext   = head[EVT_EXT_BIT];
  assign evt_break = head[EVT_BRK_BIT];

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb/tb_ps2_scan_ctrl.sv - self-checking bench for ps2_scan_ctrl
// Purpose: byte-sequence vectors with a scoreboard of expected events, plus
//          hand sequences for latency, timeout, reset and FIFO full corners.
// Ports:   none (top-level bench).
module tb_ps2_scan_ctrl;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic       evt_ready;
  logic       fifo_overflow;
  logic       seq_error;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_REPEAT  (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .evt_code      (evt_code),
    .evt_ext       (evt_ext),
    .evt_break     (evt_break),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .fifo_overflow (fifo_overflow),
    .seq_error     (seq_error)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         err_cnt = 0;
  logic [9:0] sb[$];

  typedef struct {
    logic [0:9][7:0] bytes;
    int              nb;
    logic [0:3][9:0] exp;
    int              ne;
    int              nerr;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [9:0] ev(input logic [7:0] c, input logic x, input logic b);
    return {x, b, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every accepted head event is compared against the scoreboard front.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset) begin
      if (seq_error) err_cnt++;
      if (evt_valid && evt_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got %h expected none", {evt_ext, evt_break, evt_code});
        end else begin
          e = sb.pop_front();
          check("event", {22'h0, evt_ext, evt_break, evt_code}, {22'h0, e});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || evt_valid) && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) @(negedge clk);
    check(name, {31'h0, (k < 300 && sb.size() == 0)}, 32'h1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    vecs[0] = '{{8'h1C, 8'hF0, 8'h1C, 56'h0}, 3,
                {ev(8'h1C, 0, 0), ev(8'h1C, 0, 1), 20'h0}, 2, 0};
    vecs[1] = '{{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 40'h0}, 5,
                {ev(8'h75, 1, 0), ev(8'h75, 1, 1), 20'h0}, 2, 0};
    vecs[2] = '{{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h00}, 9,
                {ev(8'h1C, 0, 0), ev(8'h1C, 0, 1), ev(8'h1C, 0, 0), ev(8'h1C, 0, 1)}, 4, 0};
    vecs[3] = '{{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 16'h0}, 8,
                {ev(8'h77, 1, 0), 30'h0}, 1, 0};
    vecs[4] = '{{8'hF0, 8'hE0, 8'h29, 8'hF0, 8'h29, 40'h0}, 5,
                {ev(8'h29, 0, 0), ev(8'h29, 0, 1), 20'h0}, 2, 1};
    vecs[5] = '{{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'h5A, 8'hF0, 8'h5A, 8'h00}, 9,
                {ev(8'h5A, 0, 0), ev(8'h5A, 0, 1), 20'h0}, 2, 0};
    vecs[6] = '{{8'hE0, 8'hF0, 8'hE1, 8'hE0, 8'h1F, 8'hE0, 8'hF0, 8'h1F, 16'h0}, 8,
                {ev(8'h1F, 1, 0), ev(8'h1F, 1, 1), 20'h0}, 2, 1};
    vecs[7] = '{{8'hE0, 8'h6B, 8'hE0, 8'h6B, 8'h6B, 8'hF0, 8'h6B, 8'hE0, 8'hF0, 8'h6B}, 10,
                {ev(8'h6B, 1, 0), ev(8'h6B, 0, 0), ev(8'h6B, 0, 1), ev(8'h6B, 1, 1)}, 4, 0};

    reset     = 1'b1;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, evt_valid}, 32'h0);
    check("rst_code", {24'h0, evt_code}, 32'h0);
    check("rst_ext", {31'h0, evt_ext}, 32'h0);
    check("rst_break", {31'h0, evt_break}, 32'h0);
    check("rst_overflow", {31'h0, fifo_overflow}, 32'h0);
    check("rst_seq_error", {31'h0, seq_error}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      e0 = err_cnt;
      for (int j = 0; j < vecs[i].ne; j++) sb.push_back(vecs[i].exp[j]);
      for (int j = 0; j < vecs[i].nb; j++) send(vecs[i].bytes[j], (i == 0) ? 19 : 4);
      wait_drain("vec_drain");
      check("vec_seq_error", err_cnt - e0, vecs[i].nerr);
    end

    // Latency: event visible the cycle after rx_done.
    @(posedge clk); #1;
    rx_data = 8'h2B;
    rx_done = 1'b1;
    sb.push_back(ev(8'h2B, 0, 0));
    @(negedge clk);
    check("lat_same_cycle", {31'h0, evt_valid}, 32'h0);
    @(posedge clk); #1;
    rx_done = 1'b0;
    @(negedge clk);
    check("lat_next_cycle", {31'h0, evt_valid}, 32'h1);
    sb.push_back(ev(8'h2B, 0, 1));
    send(8'hF0, 4);
    send(8'h2B, 4);
    wait_drain("lat_drain");

    // Stalled E0 prefix times out with exactly one error and no event.
    e0 = err_cnt;
    send(8'hE0, 0);
    repeat (TMO + 20) @(negedge clk);
    check("timeout_err", err_cnt - e0, 1);
    sb.push_back(ev(8'h1C, 0, 0));
    sb.push_back(ev(8'h1C, 0, 1));
    send(8'h1C, 4);
    send(8'hF0, 4);
    send(8'h1C, 4);
    wait_drain("timeout_drain");
    check("timeout_err_after", err_cnt - e0, 1);

    // Reset mid-sequence discards the partial prefix and buffered events.
    evt_ready = 1'b0;
    send(8'h31, 2);
    send(8'h32, 2);
    send(8'hE0, 2);
    @(negedge clk);
    check("pre_rst_valid", {31'h0, evt_valid}, 32'h1);
    pulse_reset();
    @(negedge clk);
    check("mid_rst_valid", {31'h0, evt_valid}, 32'h0);
    check("mid_rst_code", {24'h0, evt_code}, 32'h0);
    evt_ready = 1'b1;
    sb.push_back(ev(8'h1C, 0, 0));
    sb.push_back(ev(8'h1C, 0, 1));
    send(8'h1C, 4);
    send(8'hF0, 4);
    send(8'h1C, 4);
    wait_drain("mid_rst_drain");

    // Overflow: six makes into a depth-4 FIFO with the consumer stalled.
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) sb.push_back(ev(8'h11 + 8'(i), 0, 0));
      send(8'h11 + 8'(i), 2);
      if (i == 3) check("ovf_not_yet", {31'h0, fifo_overflow}, 32'h0);
    end
    @(negedge clk);
    check("ovf_set", {31'h0, fifo_overflow}, 32'h1);
    check("ovf_head", {24'h0, evt_code}, 32'h11);
    @(posedge clk); #1;
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ovf_drain_valid", {31'h0, evt_valid}, 32'h1);
    end
    @(negedge clk);
    check("ovf_empty", {31'h0, evt_valid}, 32'h0);
    check("ovf_sb_empty", sb.size(), 0);
    check("ovf_sticky", {31'h0, fifo_overflow}, 32'h1);
    pulse_reset();
    @(negedge clk);
    check("ovf_cleared", {31'h0, fifo_overflow}, 32'h0);

    // Full FIFO with simultaneous push and pop: nothing lost.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ev(8'h21 + 8'(i), 0, 0));
      send(8'h21 + 8'(i), 2);
    end
    @(posedge clk); #1;
    rx_data   = 8'h25;
    rx_done   = 1'b1;
    evt_ready = 1'b1;
    sb.push_back(ev(8'h25, 0, 0));
    @(posedge clk); #1;
    rx_done = 1'b0;
    wait_drain("full_pushpop_drain");
    check("full_pushpop_ovf", {31'h0, fifo_overflow}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
